// File: rtl/cordic_phase_detector_pkg.sv
// Shared CORDIC constants, datapath payload types and the arctangent table (Q4.28 radians).
package cordic_phase_detector_pkg;

    localparam int unsigned CORDIC_WIDTH = 16;
    localparam int unsigned PHASE_WIDTH  = 32;
    localparam int unsigned ITERATIONS   = 16;
    localparam int unsigned EXT_WIDTH    = CORDIC_WIDTH + 2;
    localparam int unsigned MAG_WIDTH    = CORDIC_WIDTH + 2;
    localparam int unsigned CNT_WIDTH    = 5;

    localparam logic signed [PHASE_WIDTH-1:0] SFIXED_PI      = 32'sh3243F6A8;
    localparam logic signed [PHASE_WIDTH-1:0] SFIXED_TWO_PI  = 32'sh6487ED51;
    localparam logic signed [PHASE_WIDTH-1:0] SFIXED_HALF_PI = 32'sh1921FB54;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Working vector of the micro-rotation engine (x, y two's complement; z phase accumulator).
    typedef struct packed {
        logic [EXT_WIDTH-1:0]   x;
        logic [EXT_WIDTH-1:0]   y;
        logic [PHASE_WIDTH-1:0] z;
    } cordic_vec_t;

    // Result payload presented on the output side.
    typedef struct packed {
        logic [PHASE_WIDTH-1:0] phase;
        logic [MAG_WIDTH-1:0]   mag;
        logic [PHASE_WIDTH-1:0] freq;
        logic                   freq_valid;
    } result_t;

    // atan(2^-i) in Q4.28, i = 0..23.
    function automatic logic [PHASE_WIDTH-1:0] atan_lut(input logic [CNT_WIDTH-1:0] idx);
        logic [PHASE_WIDTH-1:0] a;
        case (idx)
            5'd0:    a = 32'h0C90FDAA;
            5'd1:    a = 32'h076B19C1;
            5'd2:    a = 32'h03EB6EBF;
            5'd3:    a = 32'h01FD5BA9;
            5'd4:    a = 32'h00FFAADD;
            5'd5:    a = 32'h007FF556;
            5'd6:    a = 32'h003FFEAA;
            5'd7:    a = 32'h001FFFD5;
            5'd8:    a = 32'h000FFFFA;
            5'd9:    a = 32'h0007FFFF;
            5'd10:   a = 32'h0003FFFF;
            5'd11:   a = 32'h0001FFFF;
            5'd12:   a = 32'h0000FFFF;
            5'd13:   a = 32'h00007FFF;
            5'd14:   a = 32'h00003FFF;
            5'd15:   a = 32'h00001FFF;
            5'd16:   a = 32'h00000FFF;
            5'd17:   a = 32'h000007FF;
            5'd18:   a = 32'h000003FF;
            5'd19:   a = 32'h000001FF;
            5'd20:   a = 32'h000000FF;
            5'd21:   a = 32'h0000007F;
            5'd22:   a = 32'h0000003F;
            5'd23:   a = 32'h0000001F;
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_phase_detector_if.sv
// I/Q sample in, phase/magnitude/frequency out; valid/ready on both sides.
interface cordic_phase_detector_if;
    import cordic_phase_detector_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic signed [CORDIC_WIDTH-1:0] x_in;
    logic signed [CORDIC_WIDTH-1:0] y_in;

    logic                           out_valid;
    logic                           out_ready;
    logic signed [PHASE_WIDTH-1:0]  phase_out;
    logic        [MAG_WIDTH-1:0]    mag_out;
    logic signed [PHASE_WIDTH-1:0]  freq_out;
    logic                           freq_valid;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, phase_out, mag_out, freq_out, freq_valid
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, phase_out, mag_out, freq_out, freq_valid
    );

endinterface

// File: rtl/cordic_phase_detector_phase_diff_wrap.sv
// Combinational a - b wrapped into [-pi, +pi); the difference is formed one bit wider so it cannot overflow.
module cordic_phase_detector_phase_diff_wrap
    import cordic_phase_detector_pkg::*;
(
    input  logic [PHASE_WIDTH-1:0] a,
    input  logic [PHASE_WIDTH-1:0] b,
    output logic [PHASE_WIDTH-1:0] diff
);

    logic signed [PHASE_WIDTH:0] raw;
    logic signed [PHASE_WIDTH:0] wrapped;
    logic signed [PHASE_WIDTH:0] pi_ext;
    logic signed [PHASE_WIDTH:0] two_pi_ext;

    // Single-step wrap: inputs are phases in about [-pi, +pi], so one 2*pi correction suffices.
    always_comb begin
        pi_ext     = {SFIXED_PI[PHASE_WIDTH-1], SFIXED_PI};
        two_pi_ext = {SFIXED_TWO_PI[PHASE_WIDTH-1], SFIXED_TWO_PI};
        raw        = {a[PHASE_WIDTH-1], a} - {b[PHASE_WIDTH-1], b};
        wrapped    = raw;
        if (raw >= pi_ext) begin
            wrapped = raw - two_pi_ext;
        end else if (raw < -pi_ext) begin
            wrapped = raw + two_pi_ext;
        end
        diff = PHASE_WIDTH'(wrapped);
    end

endmodule

// File: rtl/cordic_phase_detector.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2 phase, uncompensated magnitude and
// wrapped phase step versus the previous sample. One micro-rotation per clock.
module cordic_phase_detector
    import cordic_phase_detector_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    cordic_phase_detector_if.slave bus
);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;
    cordic_vec_t            vec_q;
    cordic_vec_t            vec_next;
    result_t                res_q;
    result_t                res_next;
    logic [PHASE_WIDTH-1:0] prev_phase;
    logic [PHASE_WIDTH-1:0] prev_phase_next;
    logic                   have_prev;
    logic                   have_prev_next;
    logic                   zero_in;
    logic                   zero_in_next;
    logic                   in_ready_q;
    logic                   in_ready_next;
    logic                   out_valid_q;
    logic                   out_valid_next;

    logic signed [EXT_WIDTH-1:0]   x_cur;
    logic signed [EXT_WIDTH-1:0]   y_cur;
    logic signed [EXT_WIDTH-1:0]   x_shr;
    logic signed [EXT_WIDTH-1:0]   y_shr;
    logic signed [EXT_WIDTH-1:0]   x_ext;
    logic signed [EXT_WIDTH-1:0]   y_ext;
    logic signed [PHASE_WIDTH-1:0] z_cur;
    logic signed [PHASE_WIDTH-1:0] atan_cur;
    logic [PHASE_WIDTH-1:0]        phase_final;
    logic [PHASE_WIDTH-1:0]        freq_wrap_c;

    // A zero vector has no angle; report 0 rather than the accumulated rotation sum.
    assign phase_final = zero_in ? '0 : vec_q.z;

    cordic_phase_detector_phase_diff_wrap u_wrap (
        .a    (phase_final),
        .b    (prev_phase),
        .diff (freq_wrap_c)
    );

    // Next-state and datapath update: pre-rotate on accept, rotate towards y=0, publish on DONE entry.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        vec_next        = vec_q;
        res_next        = res_q;
        prev_phase_next = prev_phase;
        have_prev_next  = have_prev;
        zero_in_next    = zero_in;
        out_valid_next  = out_valid_q;
        in_ready_next   = 1'b0;

        x_cur    = $signed(vec_q.x);
        y_cur    = $signed(vec_q.y);
        z_cur    = $signed(vec_q.z);
        x_shr    = x_cur >>> cnt;
        y_shr    = y_cur >>> cnt;
        atan_cur = $signed(atan_lut(cnt));
        x_ext    = {{(EXT_WIDTH-CORDIC_WIDTH){bus.x_in[CORDIC_WIDTH-1]}}, bus.x_in};
        y_ext    = {{(EXT_WIDTH-CORDIC_WIDTH){bus.y_in[CORDIC_WIDTH-1]}}, bus.y_in};

        case (state)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    zero_in_next = (bus.x_in == '0) && (bus.y_in == '0);
                    cnt_next     = '0;
                    // Left half-plane is folded by 180 degrees so the iterations only cover +-pi/2.
                    if (!x_ext[EXT_WIDTH-1]) begin
                        vec_next.x = x_ext;
                        vec_next.y = y_ext;
                        vec_next.z = '0;
                    end else begin
                        vec_next.x = -x_ext;
                        vec_next.y = -y_ext;
                        vec_next.z = y_ext[EXT_WIDTH-1] ? -SFIXED_PI : SFIXED_PI;
                    end
                    state_next = ST_ITER;
                end
            end

            ST_ITER: begin
                if (!y_cur[EXT_WIDTH-1]) begin
                    vec_next.x = x_cur + y_shr;
                    vec_next.y = y_cur - x_shr;
                    vec_next.z = z_cur + atan_cur;
                end else begin
                    vec_next.x = x_cur - y_shr;
                    vec_next.y = y_cur + x_shr;
                    vec_next.z = z_cur - atan_cur;
                end
                cnt_next = cnt + CNT_WIDTH'(1);
                if (cnt == CNT_WIDTH'(ITERATIONS - 1)) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!out_valid_q) begin
                    res_next.phase      = phase_final;
                    res_next.mag        = vec_q.x;
                    res_next.freq       = freq_wrap_c;
                    res_next.freq_valid = have_prev;
                    prev_phase_next     = phase_final;
                    have_prev_next      = 1'b1;
                    out_valid_next      = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        in_ready_next = (state_next == ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            vec_q       <= '0;
            res_q       <= '0;
            prev_phase  <= '0;
            have_prev   <= 1'b0;
            zero_in     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            vec_q       <= vec_next;
            res_q       <= res_next;
            prev_phase  <= prev_phase_next;
            have_prev   <= have_prev_next;
            zero_in     <= zero_in_next;
            in_ready_q  <= in_ready_next;
            out_valid_q <= out_valid_next;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.phase_out  = res_q.phase;
    assign bus.mag_out    = res_q.mag;
    assign bus.freq_out   = res_q.freq;
    assign bus.freq_valid = res_q.freq_valid;

endmodule
